dmem_bus_arbiter: RTL and testbench

Shares the single-port data memory between two requesters: the CPU load/store path and the UART program loader, which writes memory during upgrade mode. It sits between the memory/IO steering logic and the data-memory block RAM. It sequences each access (issue, read-latency wait, acknowledge), arbitrates conflicts, and produces the CPU stall signal.

---
 rtl/dmem_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter.sv
// Data-memory arbiter between the CPU load/store path and the UART loader.
// Optional grant/conflict statistics are enabled with `define ARB_STATS_EN.
module dmem_bus_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              upg_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              uart_req,
    input  logic              uart_we,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    output logic              uart_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_cpu,
    output logic              busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       cpu_grant_cnt,
    output logic [15:0]       uart_grant_cnt,
    output logic [15:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic {OWN_CPU, OWN_UART} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          wait_q, wait_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic cpu_elig;
    logic grant_cpu;
    logic grant_uart;

    // Ties go to whoever did not win last time, giving strict alternation.
    assign cpu_elig   = cpu_req & ~upg_mode;
    assign grant_cpu  = (state_q == S_IDLE) & cpu_elig & (~uart_req | (last_q == OWN_UART));
    assign grant_uart = (state_q == S_IDLE) & uart_req & ~grant_cpu;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_cpu) begin
                    owner_d = OWN_CPU;
                    last_d  = OWN_CPU;
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = S_ISSUE;
                end else if (grant_uart) begin
                    owner_d = OWN_UART;
                    last_d  = OWN_UART;
                    we_d    = uart_we;
                    addr_d  = uart_addr;
                    wdata_d = uart_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d  = 2'(RD_LAT - 1);
                state_d = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 2'd0) begin
                    if (owner_q == OWN_CPU) rdata_d = mem_rdata;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= OWN_CPU;
            last_q  <= OWN_UART;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= 2'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
        end
    end

    // Address/data registers double as the memory bus so they hold between accesses.
    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = (state_q == S_DONE) & (owner_q == OWN_CPU);
    assign uart_ack  = (state_q == S_DONE) & (owner_q == OWN_UART);
    assign cpu_rdata = rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign stall_cpu = upg_mode | (cpu_req & ~cpu_ack);

`ifdef ARB_STATS_EN
    logic [15:0] cpu_cnt_q, cpu_cnt_d;
    logic [15:0] uart_cnt_q, uart_cnt_d;
    logic [15:0] conf_cnt_q, conf_cnt_d;

    always_comb begin
        cpu_cnt_d  = cpu_cnt_q;
        uart_cnt_d = uart_cnt_q;
        conf_cnt_d = conf_cnt_q;
        if (grant_cpu && cpu_cnt_q != 16'hFFFF) cpu_cnt_d = cpu_cnt_q + 16'd1;
        if (grant_uart && uart_cnt_q != 16'hFFFF) uart_cnt_d = uart_cnt_q + 16'd1;
        if ((state_q == S_IDLE) && cpu_elig && uart_req && conf_cnt_q != 16'hFFFF)
            conf_cnt_d = conf_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_cnt_q  <= '0;
            uart_cnt_q <= '0;
            conf_cnt_q <= '0;
        end else begin
            cpu_cnt_q  <= cpu_cnt_d;
            uart_cnt_q <= uart_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign cpu_grant_cnt  = cpu_cnt_q;
    assign uart_grant_cnt = uart_cnt_q;
    assign conflict_cnt   = conf_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Randomized bench for dmem_bus_arbiter: transaction-level reference model
// predicts grant order, ack timing, bus contents and read data.
module tb_dmem_bus_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              upg_mode;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              uart_req, uart_we;
    logic [ADDR_W-1:0] uart_addr;
    logic [DATA_W-1:0] uart_wdata;
    logic              uart_ack;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_cpu, busy;
`ifdef ARB_STATS_EN
    logic [15:0] cpu_grant_cnt, uart_grant_cnt, conflict_cnt;
`endif

    dmem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset), .upg_mode(upg_mode),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_ack(uart_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cpu(stall_cpu), .busy(busy)
`ifdef ARB_STATS_EN
        , .cpu_grant_cnt(cpu_grant_cnt), .uart_grant_cnt(uart_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Environment memory with RD_LAT-cycle registered read.
    logic [DATA_W-1:0] mem     [64];
    logic [DATA_W-1:0] ref_mem [64];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    assign mem_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
            rd_pipe[0] <= mem[mem_addr[5:0]];
        end
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    int n_checks = 0;
    int n_errors = 0;
    bit last_was_cpu = 1'b0;
    int cpu_grants = 0, uart_grants = 0, conflicts = 0;
    logic [DATA_W-1:0] last_cpu_rd = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ref_tx(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          output logic [DATA_W-1:0] rd);
        rd = ref_mem[a[5:0]];
        if (we) ref_mem[a[5:0]] = d;
    endtask

    task automatic scramble(input bit is_cpu);
        if (is_cpu) begin
            cpu_we = 1'($urandom); cpu_addr = 14'($urandom); cpu_wdata = $urandom;
        end else begin
            uart_we = 1'($urandom); uart_addr = 14'($urandom); uart_wdata = $urandom;
        end
    endtask

    // One scenario starting in IDLE: up to one request per side raised together.
    task automatic run_scn(input bit c_en, input bit u_en, input bit c_we, input bit u_we,
                           input logic [ADDR_W-1:0] c_a, input logic [ADDR_W-1:0] u_a,
                           input logic [DATA_W-1:0] c_d, input logic [DATA_W-1:0] u_d,
                           input bit upg);
        bit ce, first_cpu;
        int n_tx, lat_c, lat_u, lf, ls, c_ack, u_ack, end_n;
        bit e_we [2];
        logic [ADDR_W-1:0] e_a [2];
        logic [DATA_W-1:0] e_d [2];
        logic [DATA_W-1:0] rd, exp_c_rd;
        bit exp_busy, exp_en;
        int slot;

        ce = c_en && !upg;
        n_tx = int'(ce) + int'(u_en);
        first_cpu = ce && (!u_en || !last_was_cpu);
        lat_c = c_we ? 3 : 3 + RD_LAT;
        lat_u = u_we ? 3 : 3 + RD_LAT;
        c_ack = -1; u_ack = -1; lf = 0; ls = 0; end_n = 3;
        exp_c_rd = last_cpu_rd;
        if (n_tx > 0) begin
            lf = first_cpu ? lat_c : lat_u;
            ls = (n_tx == 2) ? (first_cpu ? lat_u : lat_c) : 0;
            end_n = lf + ls;
            for (int k = 0; k < n_tx; k++) begin
                bit is_cpu;
                is_cpu = (k == 0) ? first_cpu : !first_cpu;
                e_we[k] = is_cpu ? c_we : u_we;
                e_a[k]  = is_cpu ? c_a : u_a;
                e_d[k]  = is_cpu ? c_d : u_d;
                ref_tx(e_we[k], e_a[k], e_d[k], rd);
                if (is_cpu) begin
                    c_ack = (k == 0) ? lf - 1 : lf + ls - 1;
                    if (!c_we) exp_c_rd = rd;
                end else begin
                    u_ack = (k == 0) ? lf - 1 : lf + ls - 1;
                end
            end
            if (ce) cpu_grants++;
            if (u_en) uart_grants++;
            if (ce && u_en) conflicts++;
            last_was_cpu = (n_tx == 2) ? !first_cpu : ce;
        end

        upg_mode = upg;
        cpu_req = c_en; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
        uart_req = u_en; uart_we = u_we; uart_addr = u_a; uart_wdata = u_d;

        for (int n = 0; n <= end_n; n++) begin
            @(negedge clock);
            check("cpu_ack", cpu_ack, (n == c_ack));
            check("uart_ack", uart_ack, (n == u_ack));
            if (n == c_ack && !c_we) check("cpu_rdata", cpu_rdata, exp_c_rd);
            slot = -1;
            if (n_tx > 0 && n == 1) slot = 0;
            if (n_tx == 2 && n == lf + 1) slot = 1;
            exp_en = (slot >= 0);
            check("mem_en", mem_en, exp_en);
            if (exp_en) begin
                check("mem_we", mem_we, e_we[slot]);
                check("mem_addr", mem_addr, e_a[slot]);
                if (e_we[slot]) check("mem_wdata", mem_wdata, e_d[slot]);
            end else begin
                check("mem_we_idle", mem_we, 1'b0);
            end
            exp_busy = (n_tx > 0) && ((n >= 1 && n <= lf - 1) ||
                       (n_tx == 2 && n >= lf + 1 && n <= lf + ls - 1));
            check("busy", busy, exp_busy);
            check("stall_cpu", stall_cpu, upg | (cpu_req & (n != c_ack)));
            if (n == end_n) check("cpu_rdata_hold", cpu_rdata, exp_c_rd);
            @(posedge clock); #1;
            if (n == c_ack) cpu_req = 1'b0;
            if (n == u_ack) uart_req = 1'b0;
            if (n_tx > 0 && n == 0) scramble(first_cpu);
            if (n_tx == 2 && n == lf) scramble(!first_cpu);
        end
        cpu_req = 1'b0;
        uart_req = 1'b0;
        last_cpu_rd = exp_c_rd;
    endtask

    initial begin
        int seen;
        logic [DATA_W-1:0] rd;
        logic [ADDR_W-1:0] a;

        for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
        reset = 1'b0; upg_mode = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        uart_req = 1'b0; uart_we = 1'b0; uart_addr = '0; uart_wdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_cpu_ack", cpu_ack, 1'b0);
        check("rst_uart_ack", uart_ack, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_cpu_rdata", cpu_rdata, '0);
        check("rst_busy", busy, 1'b0);
        @(posedge clock); #1;

        // Directed: CPU write then read back, then tied conflicts.
        run_scn(1, 0, 1, 0, 14'h010, '0, 32'hDEADBEEF, '0, 0);
        run_scn(1, 0, 0, 0, 14'h010, '0, '0, '0, 0);
        for (int i = 0; i < 2; i++)
            run_scn(1, 1, 1, 1, 14'(i), 14'(i + 8), $urandom, $urandom, 0);

        // Upgrade mode: loader writes while the CPU keeps requesting.
        for (int i = 0; i < 4; i++)
            run_scn(1, 1, 1, 1, 14'h020, 14'(i), $urandom, $urandom, 1);
        run_scn(1, 0, 1, 0, 14'h021, '0, $urandom, '0, 0);

        // Random mix.
        for (int t = 0; t < 60; t++)
            run_scn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    14'($urandom_range(0, 15)), 14'($urandom_range(0, 15)),
                    $urandom, $urandom, ($urandom_range(0, 4) == 0));

        // upg_mode rises during the ISSUE cycle of a CPU read.
        a = 14'($urandom_range(0, 15));
        ref_tx(1'b0, a, '0, rd);
        cpu_grants++; last_was_cpu = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        @(posedge clock); #1 upg_mode = 1'b1;
        seen = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (cpu_ack && seen < 0) begin
                seen = k;
                check("upg_rise_rdata", cpu_rdata, rd);
            end
            @(posedge clock); #1;
            if (seen == k) cpu_req = 1'b0;
        end
        check("upg_rise_ack_cycle", 64'(seen), 64'(3));
        last_cpu_rd = rd;
        cpu_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("upg_block_ack", cpu_ack, 1'b0);
            check("upg_block_busy", busy, 1'b0);
            @(posedge clock); #1;
        end
        cpu_req = 1'b0; upg_mode = 1'b0;

        // Reset during WAIT of a loader read.
        uart_req = 1'b1; uart_we = 1'b0; uart_addr = 14'h005;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("rst_wait_mem_en", mem_en, 1'b0);
        check("rst_wait_busy", busy, 1'b0);
        check("rst_wait_uart_ack", uart_ack, 1'b0);
        check("rst_wait_cpu_rdata", cpu_rdata, '0);
        uart_req = 1'b0;
        @(negedge clock);
        check("rst_hold_uart_ack", uart_ack, 1'b0);
        @(posedge clock); #1 reset = 1'b1;
        last_was_cpu = 1'b0; last_cpu_rd = '0;
        cpu_grants = 0; uart_grants = 0; conflicts = 0;
        run_scn(1, 0, 1, 0, 14'h011, '0, 32'hCAFEF00D, '0, 0);
        run_scn(1, 1, 0, 1, 14'h011, 14'h012, '0, $urandom, 0);

`ifdef ARB_STATS_EN
        @(negedge clock);
        check("cpu_grant_cnt", cpu_grant_cnt, 16'(cpu_grants));
        check("uart_grant_cnt", uart_grant_cnt, 16'(uart_grants));
        check("conflict_cnt", conflict_cnt, 16'(conflicts));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
